jump_redirect_ctrl: RTL and testbench

Sequences unconditional jumps (j, jal, jr, jalr) resolved in decode into a single registered redirect request to fetch.
- Detects the jump in the decode-stage instruction.
- For jr/jalr, holds decode while rs is still being produced by E/M/M2.
- Captures the target and holds a valid/ready redirect to fetch until it is accepted.
- A pipeline flush from the exception path aborts it.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/jr_hazard_detect.sv | 17 +
 rtl/jump_redirect_ctrl.sv | 113 +++++++++++
 tb/tb_jump_redirect_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared decode constants and the jump-redirect FSM state type.
package cpu_pkg;
  localparam logic [5:0] OP_SPECIAL   = 6'b000000;
  localparam logic [4:0] OP_J_PREFIX  = 5'b00001;
  localparam logic [4:0] FN_JR_PREFIX = 5'b00100;

  typedef enum logic [1:0] {IDLE, WAIT_SRC, ISSUE} jctl_state_t;

  function automatic logic [31:0] j_target(input logic [31:0] pc_plus4, input logic [31:0] instr);
    return {pc_plus4[31:28], instr[25:0], 2'b00};
  endfunction
endpackage

// File: rtl/jr_hazard_detect.sv
// Combinational rs-versus-E/M/M2 producer compare; W is covered by the regfile bypass.
module jr_hazard_detect (
  input  logic       en,
  input  logic [4:0] rs,
  input  logic       regwrite_e,
  input  logic       regwrite_m,
  input  logic       regwrite_m2,
  input  logic [4:0] writereg_e,
  input  logic [4:0] writereg_m,
  input  logic [4:0] writereg_m2,
  output logic       haz
);
  assign haz = en && (rs != 5'd0) &&
               ((regwrite_e  && (writereg_e  == rs)) ||
                (regwrite_m  && (writereg_m  == rs)) ||
                (regwrite_m2 && (writereg_m2 == rs)));
endmodule

// File: rtl/jump_redirect_ctrl.sv
// Turns decode-stage j/jal/jr/jalr into one registered redirect request to fetch.
// Optional perf counters (jump_cnt, stall_cnt) are built only under `define JUMP_PERF_EN.
module jump_redirect_ctrl
  import cpu_pkg::*;
#(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              valid_d,
  input  logic [31:0]       instr_d,
  input  logic [31:0]       pc_plus4_d,
  input  logic [31:0]       src_a_d,
  input  logic              regwrite_e,
  input  logic              regwrite_m,
  input  logic              regwrite_m2,
  input  logic [4:0]        writereg_e,
  input  logic [4:0]        writereg_m,
  input  logic [4:0]        writereg_m2,
  input  logic              flush_i,
  input  logic              redir_ready,
  output logic              stall_d,
  output logic              redir_valid,
  output logic [31:0]       redir_target,
  output logic              redir_adel
`ifdef JUMP_PERF_EN
  ,
  output logic [PERF_W-1:0] jump_cnt,
  output logic [PERF_W-1:0] stall_cnt
`endif
);
  jctl_state_t state, state_nxt;
  logic        is_jr, is_j, jump, haz, load;
  logic [31:0] tgt_nxt;
  logic        adel_nxt;

  assign is_jr = (instr_d[31:26] == OP_SPECIAL) && (instr_d[5:1] == FN_JR_PREFIX);
  assign is_j  = (instr_d[31:27] == OP_J_PREFIX);
  assign jump  = valid_d && (is_jr || is_j);

  // j/jal targets are word aligned by construction, so only jr/jalr can fault
  assign tgt_nxt  = is_jr ? src_a_d : j_target(pc_plus4_d, instr_d);
  assign adel_nxt = is_jr && (src_a_d[1:0] != 2'b00);

  jr_hazard_detect u_haz (
    .en          (is_jr),
    .rs          (instr_d[25:21]),
    .regwrite_e  (regwrite_e),
    .regwrite_m  (regwrite_m),
    .regwrite_m2 (regwrite_m2),
    .writereg_e  (writereg_e),
    .writereg_m  (writereg_m),
    .writereg_m2 (writereg_m2),
    .haz         (haz)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: if (jump) begin
        state_nxt = haz ? WAIT_SRC : ISSUE;
        load      = ~haz;
      end
      WAIT_SRC: if (!haz) begin
        state_nxt = ISSUE;
        load      = 1'b1;
      end
      ISSUE: if (redir_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush_i) begin
      state_nxt = IDLE;
      load      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      redir_target <= 32'd0;
      redir_adel   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        redir_target <= tgt_nxt;
        redir_adel   <= adel_nxt;
      end
    end
  end

  assign redir_valid = (state == ISSUE);
  // gated by resetn so decode is released the moment reset asserts
  assign stall_d = resetn && !flush_i &&
                   (((state == IDLE) && jump) || (state == WAIT_SRC) ||
                    ((state == ISSUE) && !redir_ready));

  wire unused_pc = &{1'b0, pc_plus4_d[27:0]};

`ifdef JUMP_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      jump_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (redir_valid && redir_ready) jump_cnt <= jump_cnt + PERF_W'(1);
      if (stall_d) stall_cnt <= stall_cnt + PERF_W'(1);
    end
  end
`else
  localparam int unused_perf_w = PERF_W;
`endif
endmodule

// File: tb/tb_jump_redirect_ctrl.sv
// Scoreboard bench for jump_redirect_ctrl; expected redirects are queued at stimulus time.
module tb_jump_redirect_ctrl;
  typedef struct packed {logic [31:0] tgt; logic adel;} redir_t;

  logic        clk, resetn, valid_d, flush_i, redir_ready;
  logic [31:0] instr_d, pc_plus4_d, src_a_d;
  logic        regwrite_e, regwrite_m, regwrite_m2;
  logic [4:0]  writereg_e, writereg_m, writereg_m2;
  logic        stall_d, redir_valid, redir_adel;
  logic [31:0] redir_target;
`ifdef JUMP_PERF_EN
  logic [31:0] jump_cnt, stall_cnt;
`endif

  redir_t sb[$];
  redir_t mon_exp;
  int checks = 0, failures = 0;
  int exp_jumps = 0, exp_stalls = 0;

  jump_redirect_ctrl #(.PERF_W(32)) dut (
    .clk(clk), .resetn(resetn), .valid_d(valid_d), .instr_d(instr_d),
    .pc_plus4_d(pc_plus4_d), .src_a_d(src_a_d),
    .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_m2(regwrite_m2),
    .writereg_e(writereg_e), .writereg_m(writereg_m), .writereg_m2(writereg_m2),
    .flush_i(flush_i), .redir_ready(redir_ready), .stall_d(stall_d),
    .redir_valid(redir_valid), .redir_target(redir_target), .redir_adel(redir_adel)
`ifdef JUMP_PERF_EN
    , .jump_cnt(jump_cnt), .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  // handshake monitor: every accepted redirect must match the oldest queued expectation
  always @(negedge clk) begin
    #2;
    if (resetn && redir_valid && redir_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: handshake target=%h adel=%b, nothing expected", redir_target, redir_adel);
      end else begin
        mon_exp = sb.pop_front();
        if ({redir_target, redir_adel} !== mon_exp) begin
          failures++;
          $display("FAIL sb_redirect: got target=%h adel=%b, expected target=%h adel=%b",
                   redir_target, redir_adel, mon_exp.tgt, mon_exp.adel);
        end
      end
    end
  end

  function automatic logic [31:0] mk_jr(input logic [4:0] rs, input logic link);
    return {6'b000000, rs, 5'd0, (link ? 5'd31 : 5'd0), 5'd0, (link ? 6'b001001 : 6'b001000)};
  endfunction

  task automatic idle_inputs();
    valid_d = 0; instr_d = 0; pc_plus4_d = 0; src_a_d = 0; flush_i = 0; redir_ready = 0;
    regwrite_e = 0; regwrite_m = 0; regwrite_m2 = 0;
    writereg_e = 0; writereg_m = 0; writereg_m2 = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 0;
    #1;
    checks++;
    if ({redir_valid, redir_target, redir_adel, stall_d} !== 35'd0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b target=%h adel=%b stall=%b, expected all 0",
               redir_valid, redir_target, redir_adel, stall_d);
    end
`ifdef JUMP_PERF_EN
    checks++;
    if (jump_cnt !== 0 || stall_cnt !== 0) begin
      failures++;
      $display("FAIL reset_counters: jump_cnt=%0d stall_cnt=%0d, expected 0", jump_cnt, stall_cnt);
    end
`endif
    repeat (2) @(negedge clk);
    resetn = 1;
  endtask

  task automatic test_j();
    @(negedge clk);
    valid_d = 1; instr_d = {6'b000010, 26'h0000040}; pc_plus4_d = 32'hBFC0_0104; redir_ready = 1;
    sb.push_back({32'hB000_0100, 1'b0});
    exp_stalls++;
    #1; checks++;
    if (stall_d !== 1'b1 || redir_valid !== 1'b0) begin
      failures++; $display("FAIL j_detect: stall=%b valid=%b, expected stall=1 valid=0", stall_d, redir_valid);
    end
    @(negedge clk);
    exp_jumps++;
    #1; checks++;
    if (redir_valid !== 1'b1 || redir_target !== 32'hB000_0100 || redir_adel !== 1'b0 || stall_d !== 1'b0) begin
      failures++;
      $display("FAIL j_issue: valid=%b target=%h adel=%b stall=%b, expected 1 B0000100 0 0",
               redir_valid, redir_target, redir_adel, stall_d);
    end
    @(negedge clk);
    valid_d = 0;
    #1; checks++;
    if (redir_valid !== 1'b0) begin
      failures++; $display("FAIL j_idle: valid=%b, expected 0", redir_valid);
    end
  endtask

  task automatic test_jr_hazard(input int stage, input int hcyc);
    logic [31:0] tgt;
    tgt = 32'h8000_1000 + 32'(stage * 16);
    @(negedge clk);
    valid_d = 1; instr_d = mk_jr(5'd5, 1'b0); src_a_d = 32'hDEAD_0001; redir_ready = 1;
    case (stage)
      0: begin regwrite_e = 1; writereg_e = 5'd5; end
      1: begin regwrite_m = 1; writereg_m = 5'd5; end
      default: begin regwrite_m2 = 1; writereg_m2 = 5'd5; end
    endcase
    for (int i = 0; i < hcyc; i++) begin
      if (i > 0) @(negedge clk);
      exp_stalls++;
      #1; checks++;
      if (stall_d !== 1'b1 || redir_valid !== 1'b0) begin
        failures++;
        $display("FAIL jr_haz_wait s%0d c%0d: stall=%b valid=%b, expected 1 0", stage, i, stall_d, redir_valid);
      end
    end
    @(negedge clk);
    regwrite_e = 0; regwrite_m = 0; regwrite_m2 = 0; src_a_d = tgt;
    sb.push_back({tgt, 1'b0});
    exp_stalls++;
    #1; checks++;
    if (stall_d !== 1'b1 || redir_valid !== 1'b0) begin
      failures++; $display("FAIL jr_haz_release s%0d: stall=%b valid=%b, expected 1 0", stage, stall_d, redir_valid);
    end
    @(negedge clk);
    exp_jumps++;
    #1; checks++;
    if (redir_valid !== 1'b1 || redir_target !== tgt || stall_d !== 1'b0) begin
      failures++;
      $display("FAIL jr_haz_issue s%0d: valid=%b target=%h stall=%b, expected 1 %h 0",
               stage, redir_valid, redir_target, stall_d, tgt);
    end
    @(negedge clk);
    valid_d = 0;
  endtask

  task automatic test_jr_nohaz(input logic [4:0] rs, input logic we, input logic [4:0] wr,
                               input logic [31:0] src, input logic link, input logic adel);
    @(negedge clk);
    valid_d = 1; instr_d = mk_jr(rs, link); src_a_d = src; redir_ready = 1;
    regwrite_e = we; regwrite_m = we; regwrite_m2 = we;
    writereg_e = wr; writereg_m = wr; writereg_m2 = wr;
    sb.push_back({src, adel});
    exp_stalls++;
    #1; checks++;
    if (stall_d !== 1'b1) begin
      failures++; $display("FAIL jr_nohaz_detect r%0d: stall=%b, expected 1", rs, stall_d);
    end
    @(negedge clk);
    exp_jumps++;
    #1; checks++;
    if (redir_valid !== 1'b1 || redir_target !== src || redir_adel !== adel) begin
      failures++;
      $display("FAIL jr_nohaz_issue r%0d: valid=%b target=%h adel=%b, expected 1 %h %b",
               rs, redir_valid, redir_target, redir_adel, src, adel);
    end
    @(negedge clk);
    valid_d = 0; regwrite_e = 0; regwrite_m = 0; regwrite_m2 = 0;
  endtask

  task automatic test_flush();
    @(negedge clk);
    valid_d = 1; instr_d = {6'b000010, 26'h0123456}; pc_plus4_d = 32'h0040_0008; redir_ready = 0;
    exp_stalls++;
    #1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      flush_i = (c == 3);
      if (c == 4) valid_d = 0;
      #1; checks++;
      if (c < 3) begin
        exp_stalls++;
        if (redir_valid !== 1'b1 || redir_target !== 32'h0048_D158 || stall_d !== 1'b1) begin
          failures++;
          $display("FAIL bp_hold c%0d: valid=%b target=%h stall=%b, expected 1 0048d158 1",
                   c, redir_valid, redir_target, stall_d);
        end
      end else if (c == 3) begin
        if (redir_valid !== 1'b1 || stall_d !== 1'b0) begin
          failures++; $display("FAIL flush_cycle: valid=%b stall=%b, expected 1 0", redir_valid, stall_d);
        end
      end else begin
        if (redir_valid !== 1'b0 || stall_d !== 1'b0) begin
          failures++; $display("FAIL flush_abort: valid=%b stall=%b, expected 0 0", redir_valid, stall_d);
        end
      end
    end
    @(negedge clk);
    valid_d = 1; flush_i = 1; redir_ready = 1;
    #1; checks++;
    if (stall_d !== 1'b0) begin
      failures++; $display("FAIL flush_jump_stall: stall=%b, expected 0", stall_d);
    end
    @(negedge clk);
    valid_d = 0; flush_i = 0;
    #1; checks++;
    if (redir_valid !== 1'b0 || stall_d !== 1'b0) begin
      failures++; $display("FAIL flush_jump_ignored: valid=%b stall=%b, expected 0 0", redir_valid, stall_d);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    valid_d = 1; instr_d = {6'b000010, 26'h0000010}; pc_plus4_d = 32'h0040_0004; redir_ready = 1;
    sb.push_back({32'h0000_0040, 1'b0});
    exp_stalls++;
    #1;
    @(negedge clk);
    exp_jumps++;
    #1; checks++;
    if (redir_valid !== 1'b1 || redir_target !== 32'h0000_0040 || stall_d !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first: valid=%b target=%h stall=%b, expected 1 00000040 0", redir_valid, redir_target, stall_d);
    end
    @(negedge clk);
    instr_d = {6'b000011, 26'h3FF_FFFF}; pc_plus4_d = 32'h9000_0010; redir_ready = 0;
    sb.push_back({32'h9FFF_FFFC, 1'b0});
    exp_stalls++;
    #1; checks++;
    if (redir_valid !== 1'b0 || stall_d !== 1'b1) begin
      failures++; $display("FAIL b2b_second_detect: valid=%b stall=%b, expected 0 1", redir_valid, stall_d);
    end
    @(negedge clk);
    exp_stalls++;
    #1; checks++;
    if (redir_valid !== 1'b1 || redir_target !== 32'h9FFF_FFFC || stall_d !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second_wait: valid=%b target=%h stall=%b, expected 1 9ffffffc 1", redir_valid, redir_target, stall_d);
    end
    @(negedge clk);
    redir_ready = 1;
    exp_jumps++;
    #1; checks++;
    if (stall_d !== 1'b0) begin
      failures++; $display("FAIL b2b_release: stall=%b, expected 0", stall_d);
    end
    @(negedge clk);
    valid_d = 0;
    #1; checks++;
    if (redir_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_idle: valid=%b, expected 0", redir_valid);
    end
  endtask

  task automatic test_perf();
    @(negedge clk);
    #1;
`ifdef JUMP_PERF_EN
    checks++;
    if (jump_cnt !== 32'(exp_jumps) || stall_cnt !== 32'(exp_stalls)) begin
      failures++;
      $display("FAIL perf_counts: jump_cnt=%0d stall_cnt=%0d, expected %0d %0d", jump_cnt, stall_cnt, exp_jumps, exp_stalls);
    end
`endif
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    valid_d = 1; instr_d = mk_jr(5'd5, 1'b0); regwrite_m = 1; writereg_m = 5'd5; redir_ready = 1;
    @(negedge clk);
    #1; checks++;
    if (stall_d !== 1'b1 || redir_target === 32'd0) begin
      failures++; $display("FAIL arst_pre: stall=%b target=%h, expected stall=1 target!=0", stall_d, redir_target);
    end
    #2;
    resetn = 0;
    #1; checks++;
    if ({redir_valid, redir_target, redir_adel, stall_d} !== 35'd0) begin
      failures++;
      $display("FAIL arst_outputs: valid=%b target=%h adel=%b stall=%b, expected all 0",
               redir_valid, redir_target, redir_adel, stall_d);
    end
`ifdef JUMP_PERF_EN
    checks++;
    if (jump_cnt !== 0 || stall_cnt !== 0) begin
      failures++; $display("FAIL arst_counters: jump_cnt=%0d stall_cnt=%0d, expected 0", jump_cnt, stall_cnt);
    end
`endif
    @(negedge clk);
    idle_inputs();
    resetn = 1;
    @(negedge clk);
    #1; checks++;
    if (redir_valid !== 1'b0 || stall_d !== 1'b0) begin
      failures++; $display("FAIL arst_after: valid=%b stall=%b, expected 0 0", redir_valid, stall_d);
    end
  endtask

  initial begin
    test_reset();
    test_j();
    test_jr_hazard(0, 2);
    test_jr_hazard(1, 1);
    test_jr_hazard(2, 1);
    test_jr_nohaz(5'd0, 1'b1, 5'd0, 32'h8000_2000, 1'b0, 1'b0);
    test_jr_nohaz(5'd9, 1'b0, 5'd9, 32'h8000_3004, 1'b0, 1'b0);
    test_jr_nohaz(5'd7, 1'b0, 5'd0, 32'h8000_0002, 1'b1, 1'b1);
    test_jr_nohaz(5'd7, 1'b1, 5'd6, 32'h8000_0001, 1'b1, 1'b1);
    test_flush();
    test_back_to_back();
    test_perf();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL sb_leftover: %0d redirects never accepted, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
